memory_stage: RTL

//  - MEM + WB stage of the 5-stage pipelined core; sits directly downstream of the Execute stage.
//  - Consumes the EX/MEM outputs (RFWEM, MtoRFSelM, DMWEM, ALUOutM, DMdinM, RFAM).
//  - Owns the word-addressed data memory and the MEM/WB pipeline register.
//  - Produces ResultW, RFAW and RFWEW for register-file write-back and the forwarding muxes.

---
 rtl/mips_pipe_pkg.sv | 22 ++
 rtl/memory_stage_data_memory.sv | 28 ++
 rtl/memory_stage.sv | 96 +++++++++
 3 files changed

// File: rtl/mips_pipe_pkg.sv
// Shared types and constants for the MEM/WB portion of the 5-stage pipeline.
// Default widths, the MEM/WB register layout and the data-memory index position.
package mips_pipe_pkg;

    localparam int DEF_AWL    = 6;
    localparam int DEF_DWL    = 32;
    localparam int DM_IDX_LSB = 2;

    typedef struct packed {
        logic               rfwe;
        logic               mtorfsel;
        logic [DEF_DWL-1:0] aluout;
        logic [DEF_DWL-1:0] dmout;
        logic [DEF_AWL-2:0] rfa;
    } mem_wb_t;

    // A memory access with a non-word-aligned byte address.
    function automatic logic misaligned(input logic access, input logic [1:0] byte_lsbs);
        return access & (byte_lsbs != 2'b00);
    endfunction

endpackage

// File: rtl/memory_stage_data_memory.sv
// Word-addressed data memory: combinational read, rising-edge write, no reset.
// Contents survive pipeline reset; the caller gates the write enable.
module data_memory
    import mips_pipe_pkg::*;
#(
    parameter int AWL   = DEF_AWL,
    parameter int DWL   = DEF_DWL,
    parameter int DEPTH = 2**AWL
) (
    input  logic           clk,
    input  logic           we,
    input  logic [AWL-1:0] addr,
    input  logic [DWL-1:0] din,
    output logic [DWL-1:0] dout
);

    logic [DWL-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= din;
        end
    end

    // Read sees the pre-write word during a same-index write cycle.
    assign dout = mem[addr];

endmodule

// File: rtl/memory_stage.sv
// MEM + WB stage: data memory, MEM/WB pipeline register and write-back result mux.
// Optional alignment checking is enabled by defining DM_ALIGN_CHECK_EN.
module memory_stage
    import mips_pipe_pkg::*;
#(
    parameter int AWL   = DEF_AWL,
    parameter int DWL   = DEF_DWL,
    parameter int DEPTH = 2**AWL
) (
    input  logic           CLK,
    input  logic           RSTn,
    input  logic           RFWEM,
    input  logic           MtoRFSelM,
    input  logic           DMWEM,
    input  logic [DWL-1:0] ALUOutM,
    input  logic [DWL-1:0] DMdinM,
    input  logic [AWL-2:0] RFAM,
    output logic           RFWEW,
    output logic [AWL-2:0] RFAW,
    output logic [DWL-1:0] ALUOutW,
    output logic [DWL-1:0] DMOutW,
    output logic [DWL-1:0] ResultW
`ifdef DM_ALIGN_CHECK_EN
    ,
    output logic           MisalignW
`endif
);

    logic [AWL-1:0] dm_idx;
    logic           dm_we;
    logic [DWL-1:0] dm_rdata;
    logic           rfwe_next;
    mem_wb_t        wb_reg;
    mem_wb_t        wb_next;

    // Byte address to word index; out-of-range addresses wrap naturally.
    assign dm_idx = ALUOutM[AWL+DM_IDX_LSB-1:DM_IDX_LSB];

`ifdef DM_ALIGN_CHECK_EN
    logic misalign;
    logic misalign_reg;

    assign misalign  = misaligned(DMWEM | MtoRFSelM, ALUOutM[1:0]);
    assign dm_we     = DMWEM & RSTn & ~misalign;
    assign rfwe_next = RFWEM & ~misalign;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            misalign_reg <= 1'b0;
        end else if (misalign) begin
            misalign_reg <= 1'b1;
        end
    end

    assign MisalignW = misalign_reg;
`else
    assign dm_we     = DMWEM & RSTn;
    assign rfwe_next = RFWEM;
`endif

    data_memory #(
        .AWL   (AWL),
        .DWL   (DWL),
        .DEPTH (DEPTH)
    ) u_data_memory (
        .clk  (CLK),
        .we   (dm_we),
        .addr (dm_idx),
        .din  (DMdinM),
        .dout (dm_rdata)
    );

    always_comb begin
        wb_next          = '0;
        wb_next.rfwe     = rfwe_next;
        wb_next.mtorfsel = MtoRFSelM;
        wb_next.aluout   = ALUOutM;
        wb_next.dmout    = dm_rdata;
        wb_next.rfa      = RFAM;
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            wb_reg <= '0;
        end else begin
            wb_reg <= wb_next;
        end
    end

    assign RFWEW   = wb_reg.rfwe;
    assign RFAW    = wb_reg.rfa;
    assign ALUOutW = wb_reg.aluout;
    assign DMOutW  = wb_reg.dmout;
    assign ResultW = wb_reg.mtorfsel ? wb_reg.dmout : wb_reg.aluout;

endmodule
